seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode 7-segment display.
- Shares one hex-to-segment decoder across all digits.
- Accepts new display words through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows mixed old and new data.
- Sits between the arithmetic datapath (adder sum, 0x0–0xF per digit) and the board's segment and digit-enable pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit is lit (≥1).
- GAP_CYCLES, 2, anti-ghosting cycles with all digits dark between digits (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  pending buffer empty; load accepted when load_valid & load_ready.
- load_data  input  4*NUM_DIGITS  nibble i = hex value for digit i.
- blank_mask  input  NUM_DIGITS  bit i=1 keeps digit i dark; sampled live.
- seg_out  output  7  active-low segments {g,f,e,d,c,b,a}; registered.
- dig_en_n  output  NUM_DIGITS  active-low digit enables, at most one low; registered.
- frame_done  output  1  one-cycle pulse at the end of each full scan; registered.

Behaviour:
- Reset (async, rst_n=0):
  - state=SHOW, digit index=0, dwell counter=0.
  - active register=0, pending empty.
  - seg_out=7'b1111111, dig_en_n=all 1s, frame_done=0, load_ready=1.
- FSM, two states:
  - SHOW: counter counts 0..REFRESH_DIV-1, then goes to GAP with counter cleared.
  - GAP: counter counts 0..GAP_CYCLES-1, then goes to SHOW with the index advanced; index wraps from NUM_DIGITS-1 to 0.
- Frame length is exactly NUM_DIGITS*(REFRESH_DIV+GAP_CYCLES) cycles.
- Outputs are registered from the current state/index: one-cycle latency.
  - SHOW, digit i, blank_mask[i]=0: dig_en_n[i]=0, seg_out=decode(active nibble i).
  - SHOW with blank_mask[i]=1, or any GAP cycle: dig_en_n=all 1s, seg_out=7'h7F.
- Frame boundary = last GAP cycle of digit NUM_DIGITS-1. On that edge:
  - frame_done pulses for one cycle.
  - If pending is full: active <= pending, pending cleared, load_ready returns to 1 the next cycle.
- Handshake:
  - On accept, load_data is captured into pending and load_ready drops the next cycle.
  - load_data is ignored when load_ready=0; the producer holds load_valid until accepted.
  - An accept in the same cycle as a boundary while pending is empty goes to pending and commits at the next boundary. There is no bypass.
  - A second load while pending is full stalls and is never dropped.
- Decode table (hex→seg_out):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-frame: immediate return to the reset values; pending data is discarded.
- Counter widths: ceil(log2(max(REFRESH_DIV,GAP_CYCLES)))+1. The index width is ceil(log2(NUM_DIGITS)) with explicit wrap; there is no reliance on power-of-two wrap.

Decomposition:
- Shared package seg_pkg:
  - Segment constants SEG_BLANK=7'h7F and SEG_HEX[0:15] holding the table above.
  - Scan state typedef {SHOW, GAP}.
- One sub-module, hex7seg_dec: a combinational 4-bit→7-bit lookup from seg_pkg.
  - Instanced once here and reusable by the existing adder display path.

Test Plan:
- Bench parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1; frame=20 cycles.
- Reset check:
  - Stimulus: hold rst_n=0 for 3 cycles, release.
  - Required: seg_out=7F, dig_en_n=1111 during reset; first lit cycle dig_en_n=1110 with seg_out=1000000 (digit 0, value 0); frame_done first pulses 20 cycles after release.
- Load then commit:
  - Stimulus: load_data=16'hF3A0, load_valid for 1 cycle mid-frame.
  - Required: load_ready=0 until the boundary; the next frame shows digit0=1000000, digit1=0001000, digit2=0110000, digit3=0001110; load_ready=1 after frame_done.
- Back-pressure:
  - Stimulus: two loads, 16'h1111 then 16'h2222, in consecutive cycles.
  - Required: second held (ready=0) until the boundary; frame N+1 shows all 1111001, frame N+2 shows all 0100100.
- Boundary collision:
  - Stimulus: load 16'h8888 exactly on the boundary cycle with pending empty.
  - Required: that frame still shows the old data; 0000000 appears on all digits one frame later.
- Blanking and gap:
  - Stimulus: blank_mask=4'b0100.
  - Required: digit 2 slot shows dig_en_n=1111, seg_out=7F for 4 cycles; every GAP cycle shows dig_en_n=1111; never two enables low at once.
- Mid-frame reset:
  - Stimulus: pulse rst_n=0 while on digit 2 with pending full.
  - Required: outputs go to 7F/1111 immediately; after release the scan restarts at digit 0 showing 0, pending is discarded, and load_ready=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment constants and scan-state type for the display path.
// Segment words are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment lookup.
// Shared between the scan controller and the adder display path.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// New words are buffered in a pending slot and committed only at frame ends.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic                    frame_done
);

    localparam int MAX_CNT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    scan_state_t             r_state;
    scan_state_t             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_boundary;

    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_full;
    logic                    w_accept;

    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_dig_n;
    logic                    w_lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SHOW;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Index wraps explicitly so non-power-of-two digit counts scan correctly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        case (r_state)
            SHOW: begin
                if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end
            end
            GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = SHOW;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        w_idx_nxt  = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = SHOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign load_ready = ~r_pend_full;
    assign w_accept   = load_valid & ~r_pend_full;

    // A full pending slot blocks accepts, so commit and accept never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else if (w_boundary && r_pend_full) begin
            r_active    <= r_pending;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pending   <= load_data;
            r_pend_full <= 1'b1;
        end
    end

    always_comb begin
        w_nib   = '0;
        w_dig_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_active[4*i +: 4];
                if (r_state == SHOW && !blank_mask[i]) begin
                    w_dig_n[i] = 1'b0;
                end
            end
        end
    end

    assign w_lit = ~&w_dig_n;

    hex7seg_dec u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_BLANK;
            dig_en_n   <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= w_lit ? w_seg : SEG_BLANK;
            dig_en_n   <= w_dig_n;
            frame_done <= w_boundary;
        end
    end

endmodule
